// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, halt/NOP constants
// and the opcode field position inside an instruction word.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;
  localparam logic [15:0] NOP_INSTR_DEF   = 16'h0000;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: flush (insert NOP, clear valid) beats load; neither means hold.
module ifid_pipe_reg #(
  parameter int                   ADDR_W    = 16,
  parameter int                   INSTR_W   = 16,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  pc_plus2,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_plus2_out,
  output logic               valid_out
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_plus2_q, pc_plus2_d;
  logic               valid_q, valid_d;

  // The link value is left untouched on flush; only valid gates its use downstream.
  always_comb begin
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d    = instr;
      pc_plus2_d = pc_plus2;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_plus2_out = pc_plus2_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, next-PC mux, BOOT/RUN/HALTED FSM and IF/ID register.
// Optional perf counters (fetch_count/stall_count) are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W      = 16,
  parameter int                 INSTR_W     = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int                 PC_INC      = 2,
  parameter logic [3:0]         HALT_OPCODE = HALT_OPCODE_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus2,
  output logic               ifid_valid,
  output logic               halted,
  output logic [1:0]         dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        stall_count
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;

  logic              ifid_load, ifid_flush;
  logic              fetch_evt, stall_evt;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] target_aligned;
  logic              is_halt;

  assign pc_seq         = pc_q + ADDR_W'(PC_INC);
  assign target_aligned = redirect_target & ~{{(ADDR_W-1){1'b0}}, 1'b1};
  assign is_halt        = (instr_in[OPC_MSB:OPC_LSB] == HALT_OPCODE);

  // Priority in RUN and HALTED is redirect > stall > advance; redirect ignores stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    fetch_evt  = 1'b0;
    stall_evt  = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d       = target_aligned;
          ifid_flush = 1'b1;
        end else if (stall) begin
          stall_evt = 1'b1;
        end else begin
          ifid_load = 1'b1;
          fetch_evt = 1'b1;
          if (is_halt) state_d = HALTED;
          else         pc_d    = pc_seq;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          pc_d       = target_aligned;
          ifid_flush = 1'b1;
          state_d    = RUN;
        end else if (stall) begin
          stall_evt = 1'b1;
        end else begin
          // Drains the captured halt word so decode sees it exactly once.
          ifid_flush = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  ifid_pipe_reg #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk         (clk),
    .rst         (rst),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .instr       (instr_in),
    .pc_plus2    (pc_seq),
    .instr_out   (ifid_instr),
    .pc_plus2_out(ifid_pc_plus2),
    .valid_out   (ifid_valid)
  );

  assign pc_out    = pc_q;
  assign halted    = halted_q;
  assign dbg_state = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Both counters saturate at all-ones rather than wrapping.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_evt && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (stall_evt && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = fetch_evt ^ stall_evt;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: expected IF-stage snapshots are queued when stimulus is
// set up and compared after the following clock edge (or immediately for async reset).
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  localparam int OW = 16 + 16 + 16 + 1 + 1 + 2;

  logic        clk;
  logic        rst;
  logic [15:0] pc_out;
  logic [15:0] instr_in;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  logic        halt_en;
  int          checks;
  int          pass_cnt;
  logic [OW-1:0] exp_q[$];
  string         tag_q[$];

  fetch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_out         (pc_out),
    .instr_in       (instr_in),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus2  (ifid_pc_plus2),
    .ifid_valid     (ifid_valid),
    .halted         (halted),
    .dbg_state      (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory model: non-halt words, plus an optional halt word at 0x000A
  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic hen);
    logic [15:0] w;
    if (hen && a == 16'h000A) w = 16'hF000;
    else                      w = {4'h1, a[11:0]};
    return w;
  endfunction

  always_comb instr_in = mem_word(pc_out, halt_en);

  // scoreboard
  task automatic check_head();
    logic [OW-1:0] exp_v;
    logic [OW-1:0] obs_v;
    string         tag;
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    obs_v = {pc_out, ifid_instr, ifid_pc_plus2, ifid_valid, halted, dbg_state};
    checks++;
    assert (obs_v === exp_v) pass_cnt++;
    else $error("FAIL %s: observed pc/instr/plus2/v/h/st=%h expected %h", tag, obs_v, exp_v);
  endtask

  task automatic push_exp(input logic [15:0] pc, input logic [15:0] ins, input logic [15:0] p2,
                          input logic v, input logic h, input logic [1:0] st, input string tag);
    exp_q.push_back({pc, ins, p2, v, h, st});
    tag_q.push_back(tag);
  endtask

  // driver tasks
  task automatic expect_now(input logic [15:0] pc, input logic [15:0] ins, input logic [15:0] p2,
                            input logic v, input logic h, input logic [1:0] st, input string tag);
    push_exp(pc, ins, p2, v, h, st, tag);
    check_head();
  endtask

  task automatic step(input logic [15:0] pc, input logic [15:0] ins, input logic [15:0] p2,
                      input logic v, input logic h, input logic [1:0] st, input string tag);
    push_exp(pc, ins, p2, v, h, st, tag);
    @(posedge clk);
    #1;
    check_head();
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic check_cnt(input logic [15:0] exp_f, input logic [15:0] exp_s, input string tag);
    checks++;
    assert ({fetch_count, stall_count} === {exp_f, exp_s}) pass_cnt++;
    else $error("FAIL %s: observed fetch/stall=%h/%h expected %h/%h",
                tag, fetch_count, stall_count, exp_f, exp_s);
  endtask
`endif

  initial begin
    logic [15:0] p;
    checks          = 0;
    pass_cnt        = 0;
    rst             = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 16'h0000;
    halt_en         = 1'b0;

    #12;
    expect_now(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, BOOT, "reset");
`ifdef FETCH_PERF_CNT_EN
    check_cnt(16'd0, 16'd0, "cnt_reset");
`endif
    rst = 1'b0;

    step(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, RUN, "boot_exit");
    for (int i = 0; i < 3; i++) begin
      p = 16'(2 * i);
      step(p + 16'd2, mem_word(p, 1'b0), p + 16'd2, 1'b1, 1'b0, RUN, "free_run");
    end

    stall = 1'b1;
    for (int i = 0; i < 3; i++)
      step(16'h0006, 16'h1004, 16'h0006, 1'b1, 1'b0, RUN, "stall_hold");
    stall = 1'b0;
    step(16'h0008, 16'h1006, 16'h0008, 1'b1, 1'b0, RUN, "stall_resume");
`ifdef FETCH_PERF_CNT_EN
    check_cnt(16'd4, 16'd3, "cnt_after_stall");
`endif

    halt_en = 1'b1;
    step(16'h000A, 16'h1008, 16'h000A, 1'b1, 1'b0, RUN,    "pre_halt");
    step(16'h000A, 16'hF000, 16'h000C, 1'b1, 1'b1, HALTED, "halt_capture");
    step(16'h000A, 16'h0000, 16'h000C, 1'b0, 1'b1, HALTED, "halt_drain");
    step(16'h000A, 16'h0000, 16'h000C, 1'b0, 1'b1, HALTED, "halt_idle");

    redirect_valid  = 1'b1;
    redirect_target = 16'h0020;
    step(16'h0020, 16'h0000, 16'h000C, 1'b0, 1'b0, RUN, "halt_redirect");
    redirect_valid = 1'b0;
    halt_en        = 1'b0;
    step(16'h0022, 16'h1020, 16'h0022, 1'b1, 1'b0, RUN, "post_redirect");

    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 16'h0041;
    step(16'h0040, 16'h0000, 16'h0022, 1'b0, 1'b0, RUN, "redirect_over_stall");
    stall          = 1'b0;
    redirect_valid = 1'b0;
    step(16'h0042, 16'h1040, 16'h0042, 1'b1, 1'b0, RUN, "fetch_aligned");

    redirect_valid  = 1'b1;
    redirect_target = 16'hFFFE;
    step(16'hFFFE, 16'h0000, 16'h0042, 1'b0, 1'b0, RUN, "redirect_top");
    redirect_valid = 1'b0;
    p = 16'hFFFE;
    for (int i = 0; i < 10; i++) begin
      step(p + 16'd2, mem_word(p, 1'b0), p + 16'd2, 1'b1, 1'b0, RUN, "wrap_run");
      p = p + 16'd2;
    end

    // pc is now 0x0012; assert reset between edges and check without a clock
    #2;
    rst = 1'b1;
    #1;
    expect_now(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, BOOT, "async_reset");
`ifdef FETCH_PERF_CNT_EN
    check_cnt(16'd0, 16'd0, "cnt_async_reset");
`endif
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    step(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, RUN, "boot_again");
    step(16'h0002, 16'h1000, 16'h0002, 1'b1, 1'b0, RUN, "run_again");

    // final report
    $display("%0d/%0d checks passed", pass_cnt, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch stage of the 5-stage pipeline. Owns the program counter and drives the instruction memory read address. Captures the returned instruction into the IF/ID pipeline register. Handles stall, branch/jump redirect (flush) and halt detection, and feeds the decode stage.

Parameters:
ADDR_W, 16, PC and address width
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, PC value loaded on reset
PC_INC, 2, byte increment per sequential fetch
HALT_OPCODE, 4'hF, value of instr[15:12] that halts fetch
NOP_INSTR, 16'h0000, instruction written to IF/ID on flush

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
pc_out  out  ADDR_W  current PC; connects to instruction memory ReadAddress
instr_in  in  INSTR_W  instruction memory Instruction; combinational read of pc_out, valid in the same cycle
stall  in  1  hazard unit hold request
redirect_valid  in  1  taken branch/jump from EX
redirect_target  in  ADDR_W  new PC for redirect
ifid_instr  out  INSTR_W  IF/ID instruction
ifid_pc_plus2  out  ADDR_W  IF/ID PC of captured instruction + PC_INC
ifid_valid  out  1  IF/ID holds a real instruction
halted  out  1  fetch halted

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: pc_out=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus2=0, ifid_valid=0, halted=0, state=BOOT. These values apply immediately on rst, mid-operation included.
- State machine: BOOT, RUN, HALTED.
- BOOT: one cycle after rst deasserts. PC holds and ifid_valid stays 0. Next state is RUN unconditionally; stall and redirect are ignored.
- RUN, priority redirect > stall > advance:
  - redirect_valid=1: pc<=redirect_target with bit0 forced to 0. ifid_instr<=NOP_INSTR, ifid_valid<=0. Stays in RUN, and this applies even when stall=1.
  - stall=1, no redirect: PC and all IF/ID fields hold.
  - advance: ifid_instr<=instr_in, ifid_pc_plus2<=pc+PC_INC, ifid_valid<=1. If instr_in[15:12]==HALT_OPCODE, PC holds and next state is HALTED; otherwise pc<=pc+PC_INC.
- HALTED: halted=1 (registered, asserted the cycle after the halt instruction is captured). PC holds.
  - redirect_valid=1: flush as in RUN, pc<=target, state returns to RUN, halted<=0.
  - stall=1, no redirect: IF/ID holds.
  - otherwise: ifid_valid<=0 and ifid_instr<=NOP_INSTR, so the halt instruction is passed to decode exactly once.
- Arithmetic: PC add is modulo 2^ADDR_W. 16'hFFFE + 2 wraps to 16'h0000 with no flag.
- ifid_pc_plus2 uses the same modulo add. It is the link value for jump-and-link.
- pc_out is a register output with no combinational path from any input. Latency from redirect to the new pc_out is 1 cycle.
- A misaligned redirect_target (odd) is silently aligned down.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs fetch_count[15:0] and stall_count[15:0], both reset to 0 and saturating at 16'hFFFF.
  - fetch_count increments on every advance cycle that sets ifid_valid=1.
  - stall_count increments on every RUN or HALTED cycle with stall=1 and no redirect.
- Undefined: the ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds the state encoding (BOOT=2'd0, RUN=2'd1, HALTED=2'd2), the HALT_OPCODE and NOP_INSTR constants, and the opcode field position [15:12].
- One sub-module, ifid_pipe_reg, holds the IF/ID register.
  - Inputs: instr, pc_plus2, load, flush, async rst.
  - Flush has priority over load; neither asserted means hold.
- fetch_pc_unit contains the PC register, next-PC mux, FSM and optional counters.

Test Plan:
- Reset then free run, instr_in from a memory model with non-halt words: pc_out 0000 (BOOT), 0000, 0002, 0004…; ifid_pc_plus2 0002, 0004…; ifid_valid rises the cycle after pc first advances.
- stall=1 for 3 cycles at pc=0006: pc_out and IF/ID frozen 3 cycles, then resume at 0008; with FETCH_PERF_CNT_EN, stall_count=3.
- redirect_valid=1 with stall=1, target=0x0041: next pc_out=0x0040, ifid_valid=0, ifid_instr=0000; the following cycle fetches 0x0040.
- Halt word 0xF000 at 0x000A: captured once with ifid_valid=1, halted=1 next cycle, pc stays 0x000A, ifid_valid=0 afterwards; redirect to 0x0020 resumes RUN.
- PC wrap: redirect to 0xFFFE, advance → pc_out=0x0000, ifid_pc_plus2=0x0000.
- Assert rst mid-stream at pc=0x0012 between clock edges: outputs return to reset values immediately, before the next clock edge; BOOT cycle repeats after release.
